// File: rtl/ifetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory req/ack channel plus the decode-side head port.
// imem_err/if_fault exist only when IFETCH_BUSERR_EN is defined.
interface ifetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
`ifdef IFETCH_BUSERR_EN
  logic        imem_err;
  logic        if_fault;
`endif
  logic        if_valid;
  logic        id_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  modport master (
    output imem_req, imem_addr, if_valid, if_pc, if_instr,
`ifdef IFETCH_BUSERR_EN
    output if_fault,
    input  imem_err,
`endif
    input  imem_ack, imem_rdata, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_pc, if_instr,
`ifdef IFETCH_BUSERR_EN
    input  if_fault,
    output imem_err,
`endif
    output imem_ack, imem_rdata, id_ready
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: one outstanding imem read, small {pc, instr} FIFO toward decode,
// redirect flush with in-flight discard. IFETCH_BUSERR_EN adds bus-error faulting and S_HALT.
module ifetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          BUF_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  ifetch_unit_if.master bus
);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

`ifdef IFETCH_BUSERR_EN
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD} state_t;
`endif

  state_t             state_reg, state_next;
  logic [31:0]        fetch_pc_reg, fetch_pc_next;
  logic               req_reg, req_next;
  logic [31:0]        addr_reg, addr_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [31:0]        pc_mem    [BUF_DEPTH];
  logic [31:0]        instr_mem [BUF_DEPTH];

  logic        ack, err, push, pop, room;
  logic [31:0] redirect_target;

  assign ack             = bus.imem_ack && req_reg;
`ifdef IFETCH_BUSERR_EN
  assign err             = ack && bus.imem_err;
`else
  assign err             = 1'b0;
`endif
  assign redirect_target = redirect_pc & ~32'h3;
  assign push            = (state_reg == S_REQ) && ack && !redirect_valid;
  assign pop             = (count_reg != '0) && bus.id_ready && !redirect_valid;
  assign count_next      = redirect_valid ? '0
                         : count_reg + CNT_W'(push) - CNT_W'(pop);
  assign room            = count_next < CNT_W'(BUF_DEPTH);

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    req_next      = req_reg;
    addr_next     = addr_reg;
    if (redirect_valid) begin
      fetch_pc_next = redirect_target;
      // An unacked request must stay on the bus with its old address; its data is dropped later.
      if ((state_reg == S_REQ || state_reg == S_DISCARD) && !ack) begin
        state_next = S_DISCARD;
      end else begin
        state_next = S_REQ;
        req_next   = 1'b1;
        addr_next  = redirect_target;
      end
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (room) begin
            state_next = S_REQ;
            req_next   = 1'b1;
            addr_next  = fetch_pc_reg;
          end
        end
        S_REQ: begin
          if (ack) begin
`ifdef IFETCH_BUSERR_EN
            if (err) begin
              state_next = S_HALT;
              req_next   = 1'b0;
            end else
`endif
            begin
              fetch_pc_next = fetch_pc_reg + 32'd4;
              if (room) begin
                addr_next = fetch_pc_reg + 32'd4;
              end else begin
                state_next = S_IDLE;
                req_next   = 1'b0;
              end
            end
          end
        end
        S_DISCARD: begin
          if (ack) begin
            state_next = S_REQ;
            req_next   = 1'b1;
            addr_next  = fetch_pc_reg;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      fetch_pc_reg <= RESET_ADDR;
      req_reg      <= 1'b0;
      addr_reg     <= RESET_ADDR;
      count_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      req_reg      <= req_next;
      addr_reg     <= addr_next;
      count_reg    <= count_next;
      if (redirect_valid) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]    <= addr_reg;
      instr_mem[wr_ptr_reg] <= bus.imem_rdata;
    end
  end

`ifdef IFETCH_BUSERR_EN
  logic fault_mem [BUF_DEPTH];
  always_ff @(posedge clk) begin
    if (push) fault_mem[wr_ptr_reg] <= err;
  end
  assign bus.if_fault = fault_mem[rd_ptr_reg];
`else
  logic unused_err;
  assign unused_err = err;
`endif

  assign bus.imem_req  = req_reg;
  assign bus.imem_addr = addr_reg;
  assign bus.if_valid  = (count_reg != '0);
  assign bus.if_pc     = pc_mem[rd_ptr_reg];
  assign bus.if_instr  = instr_mem[rd_ptr_reg];
endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: memory returns ~addr as the instruction word.
module tb_ifetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        auto_ack;
  logic        man_ack;
  logic        err_en;
  int          n_checks = 0;
  int          n_errors = 0;

  ifetch_unit_if bus ();

  ifetch_unit #(.RESET_ADDR(32'h0), .BUF_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.imem_ack   = auto_ack | man_ack;
    bus.imem_rdata = ~bus.imem_addr;
`ifdef IFETCH_BUSERR_EN
    bus.imem_err   = err_en && (bus.imem_addr == 32'h10);
`endif
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    auto_ack = 1'b1; man_ack = 1'b0; err_en = 1'b0;
    bus.id_ready = 1'b1;

    // Reset sequencing and zero-wait streaming
    repeat (3) tick();
    check("rst_req",   32'(bus.imem_req), 32'h0);
    check("rst_addr",  bus.imem_addr,     32'h0);
    check("rst_valid", 32'(bus.if_valid), 32'h0);
    rst = 1'b0;
    tick();
    check("s1_req",   32'(bus.imem_req), 32'h1);
    check("s1_addr",  bus.imem_addr,     32'h0);
    check("s1_valid", 32'(bus.if_valid), 32'h0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("stream_addr",  bus.imem_addr,     32'(i * 4));
      check("stream_valid", 32'(bus.if_valid), 32'h1);
      check("stream_pc",    bus.if_pc,         32'((i - 1) * 4));
      check("stream_instr", bus.if_instr,      ~32'((i - 1) * 4));
    end

    // Backpressure: two entries fill the buffer and the request drops
    bus.id_ready = 1'b0;
    do_reset();
    tick();
    tick();
    check("bp_addr4", bus.imem_addr, 32'h4);
    tick();
    check("bp_req_off", 32'(bus.imem_req), 32'h0);
    check("bp_head0",   bus.if_pc,         32'h0);
    tick();
    check("bp_req_off2", 32'(bus.imem_req), 32'h0);
    bus.id_ready = 1'b1;
    tick();
    check("bp_resume_req",  32'(bus.imem_req), 32'h1);
    check("bp_resume_addr", bus.imem_addr,     32'h8);
    check("bp_head4",       bus.if_pc,         32'h4);
    tick();
    check("bp_head8", bus.if_pc,     32'h8);
    check("bp_addrC", bus.imem_addr, 32'hC);

    // Redirect while a request waits on a slow ack
    do_reset();
    repeat (3) tick();
    check("rw_addr8", bus.imem_addr, 32'h8);
    auto_ack = 1'b0;
    tick();
    check("rw_wait_valid", 32'(bus.if_valid), 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    check("rw_hold_req",  32'(bus.imem_req), 32'h1);
    check("rw_hold_addr", bus.imem_addr,     32'h8);
    tick();
    check("rw_hold_addr2", bus.imem_addr, 32'h8);
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0; auto_ack = 1'b1;
    check("rw_new_addr",  bus.imem_addr,     32'h100);
    check("rw_dropped",   32'(bus.if_valid), 32'h0);
    tick();
    check("rw_first_pc",    bus.if_pc,    32'h100);
    check("rw_first_instr", bus.if_instr, ~32'h100);

    // Redirect coincident with ack and pop
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    tick();
    redirect_valid = 1'b0;
    check("rc_flushed", 32'(bus.if_valid), 32'h0);
    check("rc_addr",    bus.imem_addr,     32'h200);
    tick();
    check("rc_pc", bus.if_pc, 32'h200);

    // Address wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    check("wrap_a0", bus.imem_addr, 32'hFFFF_FFF8);
    tick();
    check("wrap_a1", bus.imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_a2", bus.imem_addr, 32'h0);
    check("wrap_pc", bus.if_pc,     32'hFFFF_FFFC);
    tick();
    check("wrap_pc0", bus.if_pc, 32'h0);

`ifdef IFETCH_BUSERR_EN
    // Bus error halts fetch until a redirect
    err_en = 1'b1;
    do_reset();
    repeat (6) tick();
    check("be_pc",    bus.if_pc,         32'h10);
    check("be_fault", 32'(bus.if_fault), 32'h1);
    check("be_req",   32'(bus.imem_req), 32'h0);
    tick();
    check("be_halt_req", 32'(bus.imem_req), 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    check("be_resume_addr", bus.imem_addr, 32'h40);
    tick();
    check("be_resume_pc",    bus.if_pc,         32'h40);
    check("be_resume_fault", 32'(bus.if_fault), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
